svm_stream_loader: RTL and testbench
====================================

Name: svm_stream_loader

Overview:
- Producer side of the SVM classifier's parallel input interface.
- Accepts a 16-bit valid/ready word stream from the host/sensor bridge and deserialises it into the classifier's weight, bias and sample arrays.
- Commits each array set atomically and tracks the classifier's fixed 2-cycle latency, so the host knows when class_o is valid.

Parameters:
- DIMS, 21, input feature dimensions
- INTER, 6, hidden-layer width
- CLASSES, 3, output classes; class_valid tracking assumes the classifier's 2-cycle latency
- W, 16, word width; fixed to the classifier element type

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- s_valid_i  in  1  stream word valid
- s_ready_o  out  1  stream word accepted when s_valid_i && s_ready_o
- s_data_i  in  W  stream word
- s_last_i  in  1  final word of packet
- feats_o  out  W x [DIMS][INTER]  committed layer-1 weights
- biases_o  out  W x [INTER]  committed layer-1 biases
- feats2_o  out  W x [INTER][CLASSES]  committed layer-2 weights
- biases2_o  out  W x [CLASSES]  committed layer-2 biases
- din_o  out  W x [DIMS]  committed sample
- params_valid_o  out  1  a full parameter set has been committed
- class_valid_o  out  1  one-cycle pulse when the classifier's class_o reflects the latest committed sample
- err_o  out  1  sticky packet-error flag; cleared by the next good commit
- err_code_o  out  2  0 none, 1 bad opcode, 2 short packet, 3 long packet

Behaviour:
- Reset (async, rstn_i low):
  - all output arrays 0; params_valid_o, class_valid_o, err_o 0; err_code_o 0
  - s_ready_o 0 while in reset, 1 in the first cycle after deassertion
  - FSM returns to HDR; a partially loaded packet is discarded.
- Packet framing:
  - Word 0 is the header; opcode = s_data_i[15:8], low byte ignored.
  - Opcode 0x01 PARAM: exactly NP = DIMS*INTER + INTER + INTER*CLASSES + CLASSES words follow (153 at defaults).
  - Opcode 0x02 SAMPLE: exactly DIMS words follow (21).
- Word order:
  - PARAM: feats[d][i] with d outer and i inner, then biases[i], then feats2[i][c] with i outer, then biases2[c].
  - SAMPLE: din[0..DIMS-1].
- FSM states: HDR, LD_W1, LD_B1, LD_W2, LD_B2, LD_DIN, DRAIN, COMMIT.
  - Each load state uses one index counter, advancing only on an accepted word; the state advances when the counter reaches its section size minus 1.
  - Words land in a staging copy; outputs are never modified during a load.
- s_ready_o is 1 in every state except COMMIT, where it is 0 for exactly one cycle. There is no other backpressure.
- Good packet (s_last_i coincides with the final expected word):
  - → COMMIT; on the next edge staging is copied to the outputs, then → HDR.
  - PARAM commit: params_valid_o ← 1, err_o ← 0, err_code_o ← 0.
  - SAMPLE commit: din_o updates; err_o ← 0, err_code_o ← 0.
- SAMPLE accepted while params_valid_o is 0: commits normally, but class_valid_o is not generated for it.
- class_valid_o:
  - Pulses exactly 2 cycles after the SAMPLE commit edge: classifier input register, then class register.
  - A second commit inside that window generates its own pulse.
  - A PARAM commit generates no pulse.
- Errors (no commit in any error case; outputs hold their old values):
  - s_last_i on the header, or before the final expected word: err code 2, → HDR.
  - Final expected word without s_last_i: err code 3, → DRAIN.
  - Header with an unknown opcode: err code 1, → DRAIN, unless s_last_i is set on the header, in which case → HDR.
  - DRAIN accepts and discards words until s_last_i, then → HDR.
  - Every error sets err_o = 1 and err_code_o to the code above; the latest error overwrites the code.
- Reset mid-packet: discards staging; committed outputs are zeroed by reset.

Test Plan:
- Reset, then PARAM packet with word k = k+1 (153 words, s_last_i on 153rd) → feats_o[0][0]=1, feats_o[20][5]=126, biases_o[0]=127, feats2_o[5][2]=150, biases2_o[2]=153; params_valid_o=1; s_ready_o low exactly 1 cycle.
- After PARAM, SAMPLE 0x0200 + din words 0x0010..0x0024 → din_o[20]=0x0024; class_valid_o pulses exactly 2 cycles after the commit edge.
- SAMPLE with s_last_i on the 10th data word → err_o=1, err_code_o=2, din_o unchanged, no class_valid_o; next good SAMPLE clears err_o.
- Header 0x0700 plus 5 words with s_last_i on the 5th → err_code_o=1, all 6 words accepted, outputs unchanged; next header is decoded normally.
- SAMPLE with 22 data words, s_last_i on the 22nd → err_code_o=3 after word 21, word 22 drained, no commit.
- rstn_i asserted mid-PARAM at word 80, then released → all outputs 0, params_valid_o=0; a full PARAM then loads correctly.

Source files
------------

// File: rtl/svm_stream_if.sv
// Valid/ready word stream carrying PARAM and SAMPLE packets from the host bridge
// into the SVM loader. The master drives words and the slave returns ready.
interface svm_stream_if #(
  parameter int W = 16
);
  logic         s_valid_i;
  logic         s_ready_o;
  logic [W-1:0] s_data_i;
  logic         s_last_i;

  modport master (output s_valid_i, s_data_i, s_last_i, input s_ready_o);
  modport slave  (input s_valid_i, s_data_i, s_last_i, output s_ready_o);
endinterface

// File: rtl/svm_stream_loader.sv
// Deserialises PARAM/SAMPLE packets into the SVM classifier's parallel arrays.
// Each packet commits atomically. A 2-cycle pulse pipeline mirrors the classifier latency.
module svm_stream_loader #(
  parameter int DIMS    = 21,
  parameter int INTER   = 6,
  parameter int CLASSES = 3,
  parameter int W       = 16
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  svm_stream_if.slave  s,
  output logic [W-1:0] feats_o   [DIMS][INTER],
  output logic [W-1:0] biases_o  [INTER],
  output logic [W-1:0] feats2_o  [INTER][CLASSES],
  output logic [W-1:0] biases2_o [CLASSES],
  output logic [W-1:0] din_o     [DIMS],
  output logic         params_valid_o,
  output logic         class_valid_o,
  output logic         err_o,
  output logic [1:0]   err_code_o
);

  localparam int N_W1  = DIMS * INTER;
  localparam int N_W2  = INTER * CLASSES;
  localparam int AW_W1 = (N_W1 > 1)    ? $clog2(N_W1)    : 1;
  localparam int AW_W2 = (N_W2 > 1)    ? $clog2(N_W2)    : 1;
  localparam int AW_D  = (DIMS > 1)    ? $clog2(DIMS)    : 1;
  localparam int AW_I  = (INTER > 1)   ? $clog2(INTER)   : 1;
  localparam int AW_C  = (CLASSES > 1) ? $clog2(CLASSES) : 1;
  localparam int AW_M1 = (AW_W1 > AW_W2) ? AW_W1 : AW_W2;
  localparam int AW_M2 = (AW_D > AW_I) ? AW_D : AW_I;
  localparam int AW_M3 = (AW_M1 > AW_M2) ? AW_M1 : AW_M2;
  localparam int IDX_W = (AW_M3 > AW_C) ? AW_M3 : AW_C;

  localparam logic [7:0] OP_PARAM  = 8'h01;
  localparam logic [7:0] OP_SAMPLE = 8'h02;

  localparam logic [1:0] ERR_OPCODE = 2'd1;
  localparam logic [1:0] ERR_SHORT  = 2'd2;
  localparam logic [1:0] ERR_LONG   = 2'd3;

  localparam logic [2:0] HDR    = 3'd0;
  localparam logic [2:0] LD_W1  = 3'd1;
  localparam logic [2:0] LD_B1  = 3'd2;
  localparam logic [2:0] LD_W2  = 3'd3;
  localparam logic [2:0] LD_B2  = 3'd4;
  localparam logic [2:0] LD_DIN = 3'd5;
  localparam logic [2:0] DRAIN  = 3'd6;
  localparam logic [2:0] COMMIT = 3'd7;

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] sec_last;
  logic             ready_q;
  logic             is_param;
  logic             acc;
  logic             at_end;
  logic             final_sec;
  logic [2:0]       next_sec;
  logic [7:0]       opcode;
  logic             vld_p0, vld_p1;

  logic [W-1:0] w1_stg  [N_W1];
  logic [W-1:0] b1_stg  [INTER];
  logic [W-1:0] w2_stg  [N_W2];
  logic [W-1:0] b2_stg  [CLASSES];
  logic [W-1:0] din_stg [DIMS];

  assign s.s_ready_o = ready_q;
  assign acc         = s.s_valid_i && ready_q;
  assign opcode      = s.s_data_i[W-1:W-8];
  assign at_end      = (idx == sec_last);
  assign final_sec   = (state == LD_B2) || (state == LD_DIN);

  always_comb begin
    sec_last = '0;
    next_sec = HDR;
    case (state)
      LD_W1:   begin sec_last = IDX_W'(N_W1 - 1);    next_sec = LD_B1; end
      LD_B1:   begin sec_last = IDX_W'(INTER - 1);   next_sec = LD_W2; end
      LD_W2:   begin sec_last = IDX_W'(N_W2 - 1);    next_sec = LD_B2; end
      LD_B2:   begin sec_last = IDX_W'(CLASSES - 1); next_sec = HDR;   end
      LD_DIN:  begin sec_last = IDX_W'(DIMS - 1);    next_sec = HDR;   end
      default: begin sec_last = '0;                  next_sec = HDR;   end
    endcase
  end

  // Packet framing FSM; ready drops only for the single COMMIT cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= HDR;
      idx        <= '0;
      ready_q    <= 1'b0;
      is_param   <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= 2'd0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        HDR: if (acc) begin
          idx <= '0;
          if (opcode == OP_PARAM || opcode == OP_SAMPLE) begin
            is_param <= (opcode == OP_PARAM);
            if (s.s_last_i) begin
              err_o      <= 1'b1;
              err_code_o <= ERR_SHORT;
            end else begin
              state <= (opcode == OP_PARAM) ? LD_W1 : LD_DIN;
            end
          end else begin
            err_o      <= 1'b1;
            err_code_o <= ERR_OPCODE;
            state      <= s.s_last_i ? HDR : DRAIN;
          end
        end
        LD_W1, LD_B1, LD_W2, LD_B2, LD_DIN: if (acc) begin
          if (!at_end) begin
            idx <= idx + 1'b1;
            if (s.s_last_i) begin
              err_o      <= 1'b1;
              err_code_o <= ERR_SHORT;
              state      <= HDR;
            end
          end else begin
            idx <= '0;
            if (final_sec && s.s_last_i) begin
              state   <= COMMIT;
              ready_q <= 1'b0;
            end else if (final_sec) begin
              err_o      <= 1'b1;
              err_code_o <= ERR_LONG;
              state      <= DRAIN;
            end else if (s.s_last_i) begin
              err_o      <= 1'b1;
              err_code_o <= ERR_SHORT;
              state      <= HDR;
            end else begin
              state <= next_sec;
            end
          end
        end
        DRAIN: if (acc && s.s_last_i) state <= HDR;
        COMMIT: begin
          state      <= HDR;
          err_o      <= 1'b0;
          err_code_o <= 2'd0;
        end
        default: state <= HDR;
      endcase
    end
  end

  // Staging copy: written word by word, never visible on the outputs until COMMIT.
  always_ff @(posedge clk_i) begin
    if (acc) begin
      case (state)
        LD_W1:   w1_stg[idx[AW_W1-1:0]]  <= s.s_data_i;
        LD_B1:   b1_stg[idx[AW_I-1:0]]   <= s.s_data_i;
        LD_W2:   w2_stg[idx[AW_W2-1:0]]  <= s.s_data_i;
        LD_B2:   b2_stg[idx[AW_C-1:0]]   <= s.s_data_i;
        LD_DIN:  din_stg[idx[AW_D-1:0]]  <= s.s_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      feats_o        <= '{default: '0};
      biases_o       <= '{default: '0};
      feats2_o       <= '{default: '0};
      biases2_o      <= '{default: '0};
      din_o          <= '{default: '0};
      params_valid_o <= 1'b0;
    end else if (state == COMMIT) begin
      if (is_param) begin
        for (int d = 0; d < DIMS; d++)
          for (int i = 0; i < INTER; i++)
            feats_o[AW_D'(d)][AW_I'(i)] <= w1_stg[AW_W1'(d * INTER + i)];
        for (int i = 0; i < INTER; i++) begin
          biases_o[AW_I'(i)] <= b1_stg[AW_I'(i)];
          for (int c = 0; c < CLASSES; c++)
            feats2_o[AW_I'(i)][AW_C'(c)] <= w2_stg[AW_W2'(i * CLASSES + c)];
        end
        for (int c = 0; c < CLASSES; c++)
          biases2_o[AW_C'(c)] <= b2_stg[AW_C'(c)];
        params_valid_o <= 1'b1;
      end else begin
        for (int d = 0; d < DIMS; d++)
          din_o[AW_D'(d)] <= din_stg[AW_D'(d)];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      class_valid_o <= 1'b0;
    end else begin
      // p0: commit edge, sample lands in din_o
      vld_p0 <= (state == COMMIT) && !is_param && params_valid_o;
      // p1: classifier input register captures din_o
      vld_p1 <= vld_p0;
      // p2: classifier class register holds the result
      class_valid_o <= vld_p1;
    end
  end

endmodule

// File: tb/tb_svm_stream_loader.sv
// Bench for svm_stream_loader: directed test-plan sequences, a packet table and
// random packets, all scored against a packet-level reference model.
module tb_svm_stream_loader;

  localparam int DIMS    = 21;
  localparam int INTER   = 6;
  localparam int CLASSES = 3;
  localparam int W       = 16;
  localparam int N_W1    = DIMS * INTER;
  localparam int N_W2    = INTER * CLASSES;
  localparam int NP      = N_W1 + INTER + N_W2 + CLASSES;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  svm_stream_if #(.W(W)) s_if ();

  logic [W-1:0] feats_o   [DIMS][INTER];
  logic [W-1:0] biases_o  [INTER];
  logic [W-1:0] feats2_o  [INTER][CLASSES];
  logic [W-1:0] biases2_o [CLASSES];
  logic [W-1:0] din_o     [DIMS];
  logic         params_valid_o, class_valid_o, err_o;
  logic [1:0]   err_code_o;

  svm_stream_loader #(.DIMS(DIMS), .INTER(INTER), .CLASSES(CLASSES), .W(W)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .s              (s_if),
    .feats_o        (feats_o),
    .biases_o       (biases_o),
    .feats2_o       (feats2_o),
    .biases2_o      (biases2_o),
    .din_o          (din_o),
    .params_valid_o (params_valid_o),
    .class_valid_o  (class_valid_o),
    .err_o          (err_o),
    .err_code_o     (err_code_o)
  );

  int checks   = 0;
  int failures = 0;
  int rdy_low  = 0;
  int cv_seen  = 0;

  // Reference model: committed contents and flags, derived from whole packets.
  logic [W-1:0] m_w1 [N_W1];
  logic [W-1:0] m_b1 [INTER];
  logic [W-1:0] m_w2 [N_W2];
  logic [W-1:0] m_b2 [CLASSES];
  logic [W-1:0] m_din [DIMS];
  logic         m_pv, m_err;
  logic [1:0]   m_code;
  int           m_cv, m_rdy;
  logic [W-1:0] pkt [$];

  typedef struct {
    logic [15:0] hdr;
    int          len;
    logic        exp_err;
    logic [1:0]  exp_code;
    int          exp_commit;
  } vec_t;
  vec_t vt [10];

  always @(posedge clk_i) begin
    if (rstn_i) begin
      if (class_valid_o) cv_seen++;
      if (!s_if.s_ready_o) rdy_low++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N_W1; k++) m_w1[k] = '0;
    for (int k = 0; k < INTER; k++) m_b1[k] = '0;
    for (int k = 0; k < N_W2; k++) m_w2[k] = '0;
    for (int k = 0; k < CLASSES; k++) m_b2[k] = '0;
    for (int k = 0; k < DIMS; k++) m_din[k] = '0;
    m_pv = 0; m_err = 0; m_code = 0; m_cv = 0; m_rdy = 0;
  endtask

  // Outcome of a packet whose only s_last_i is on its final word.
  task automatic model_pkt();
    logic [7:0] op;
    int len, need, p;
    op   = pkt[0][15:8];
    len  = pkt.size() - 1;
    need = (op == 8'h01) ? NP : (op == 8'h02) ? DIMS : 0;
    if (need == 0)        begin m_err = 1; m_code = 2'd1; end
    else if (len < need)  begin m_err = 1; m_code = 2'd2; end
    else if (len > need)  begin m_err = 1; m_code = 2'd3; end
    else begin
      m_err = 0; m_code = 0; m_rdy++;
      p = 1;
      if (op == 8'h01) begin
        for (int k = 0; k < N_W1; k++) m_w1[k] = pkt[p++];
        for (int k = 0; k < INTER; k++) m_b1[k] = pkt[p++];
        for (int k = 0; k < N_W2; k++) m_w2[k] = pkt[p++];
        for (int k = 0; k < CLASSES; k++) m_b2[k] = pkt[p++];
        m_pv = 1;
      end else begin
        for (int k = 0; k < DIMS; k++) m_din[k] = pkt[p++];
        if (m_pv) m_cv++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int bad;
    bad = 0;
    for (int d = 0; d < DIMS; d++)
      for (int i = 0; i < INTER; i++) if (feats_o[d][i] !== m_w1[d*INTER+i]) bad++;
    chk({tag, "_feats_mismatches"}, bad, 0);
    bad = 0;
    for (int i = 0; i < INTER; i++) if (biases_o[i] !== m_b1[i]) bad++;
    chk({tag, "_biases_mismatches"}, bad, 0);
    bad = 0;
    for (int i = 0; i < INTER; i++)
      for (int c = 0; c < CLASSES; c++) if (feats2_o[i][c] !== m_w2[i*CLASSES+c]) bad++;
    chk({tag, "_feats2_mismatches"}, bad, 0);
    bad = 0;
    for (int c = 0; c < CLASSES; c++) if (biases2_o[c] !== m_b2[c]) bad++;
    chk({tag, "_biases2_mismatches"}, bad, 0);
    bad = 0;
    for (int d = 0; d < DIMS; d++) if (din_o[d] !== m_din[d]) bad++;
    chk({tag, "_din_mismatches"}, bad, 0);
    chk({tag, "_params_valid"}, params_valid_o, m_pv);
    chk({tag, "_err"}, err_o, m_err);
    chk({tag, "_err_code"}, err_code_o, m_code);
    chk({tag, "_class_valid_pulses"}, cv_seen, m_cv);
    chk({tag, "_ready_low_cycles"}, rdy_low, m_rdy);
  endtask

  task automatic send(input logic [W-1:0] d, input logic l);
    int t;
    t = 0;
    s_if.s_valid_i = 1'b1;
    s_if.s_data_i  = d;
    s_if.s_last_i  = l;
    while (!s_if.s_ready_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 20) chk("send_ready_timeout", t, 0);
    @(negedge clk_i);
    s_if.s_valid_i = 1'b0;
    s_if.s_last_i  = 1'b0;
  endtask

  task automatic build_pkt(input logic [15:0] hdr, input int len);
    pkt.delete();
    pkt.push_back(hdr);
    for (int k = 0; k < len; k++) pkt.push_back(W'($urandom));
  endtask

  task automatic send_pkt();
    for (int k = 0; k < pkt.size(); k++) send(pkt[k], k == pkt.size() - 1);
  endtask

  task automatic do_reset();
    s_if.s_valid_i = 1'b0;
    s_if.s_last_i  = 1'b0;
    s_if.s_data_i  = '0;
    rstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("ready_in_reset", s_if.s_ready_o, 0);
    model_clear();
    rdy_low = 0;
    cv_seen = 0;
    check_all("reset");
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("ready_after_reset", s_if.s_ready_o, 1);
    rdy_low = 0;
  endtask

  task automatic param_count_pkt();
    pkt.delete();
    pkt.push_back(16'h0100);
    for (int k = 0; k < NP; k++) pkt.push_back(W'(k + 1));
  endtask

  initial begin
    vt[0] = '{16'h0200, 10,  1'b1, 2'd2, 0};
    vt[1] = '{16'h0200, 21,  1'b0, 2'd0, 1};
    vt[2] = '{16'h0700, 5,   1'b1, 2'd1, 0};
    vt[3] = '{16'h0200, 21,  1'b0, 2'd0, 1};
    vt[4] = '{16'h0200, 0,   1'b1, 2'd2, 0};
    vt[5] = '{16'h0955, 0,   1'b1, 2'd1, 0};
    vt[6] = '{16'h02FF, 21,  1'b0, 2'd0, 1};
    vt[7] = '{16'h0100, 100, 1'b1, 2'd2, 0};
    vt[8] = '{16'h0100, 154, 1'b1, 2'd3, 0};
    vt[9] = '{16'h0100, 153, 1'b0, 2'd0, 1};

    s_if.s_valid_i = 1'b0;
    s_if.s_last_i  = 1'b0;
    s_if.s_data_i  = '0;
    @(negedge clk_i);
    do_reset();

    param_count_pkt();
    send_pkt();
    model_pkt();
    repeat (4) @(negedge clk_i);
    chk("feats_0_0", feats_o[0][0], 1);
    chk("feats_20_5", feats_o[20][5], 126);
    chk("biases_0", biases_o[0], 127);
    chk("feats2_5_2", feats2_o[5][2], 150);
    chk("biases2_2", biases2_o[2], 153);
    check_all("param_count");

    pkt.delete();
    pkt.push_back(16'h0200);
    for (int k = 0; k < DIMS; k++) pkt.push_back(W'(16'h0010 + k));
    send_pkt();
    chk("ready_in_commit", s_if.s_ready_o, 0);
    @(negedge clk_i);
    chk("din_20_after_commit", din_o[20], 16'h0024);
    chk("cv_commit_plus0", class_valid_o, 0);
    chk("ready_after_commit", s_if.s_ready_o, 1);
    @(negedge clk_i);
    chk("cv_commit_plus1", class_valid_o, 0);
    @(negedge clk_i);
    chk("cv_commit_plus2", class_valid_o, 1);
    @(negedge clk_i);
    chk("cv_commit_plus3", class_valid_o, 0);
    model_pkt();
    check_all("sample_timing");

    for (int v = 0; v < 10; v++) begin
      int r0;
      r0 = rdy_low;
      build_pkt(vt[v].hdr, vt[v].len);
      send_pkt();
      repeat (4) @(negedge clk_i);
      chk($sformatf("vec%0d_err", v), err_o, vt[v].exp_err);
      chk($sformatf("vec%0d_err_code", v), err_code_o, vt[v].exp_code);
      chk($sformatf("vec%0d_commits", v), rdy_low - r0, vt[v].exp_commit);
      model_pkt();
      check_all($sformatf("vec%0d", v));
    end

    build_pkt(16'h0200, DIMS + 1);
    for (int k = 0; k <= DIMS; k++) send(pkt[k], 1'b0);
    chk("long_code_after_word21", err_code_o, 2'd3);
    chk("long_err_after_word21", err_o, 1);
    send(pkt[DIMS + 1], 1'b1);
    model_pkt();
    repeat (4) @(negedge clk_i);
    check_all("long_drain");

    build_pkt(16'h0100, NP);
    for (int k = 0; k <= 80; k++) send(pkt[k], 1'b0);
    chk("outputs_held_during_load", feats_o[0][0], m_w1[0]);
    do_reset();
    build_pkt(16'h0200, DIMS);
    send_pkt();
    model_pkt();
    repeat (4) @(negedge clk_i);
    check_all("sample_no_params");
    param_count_pkt();
    send_pkt();
    model_pkt();
    repeat (4) @(negedge clk_i);
    chk("reload_feats_20_5", feats_o[20][5], 126);
    check_all("param_after_reset");

    for (int r = 0; r < 24; r++) begin
      int sel, kind, need, len;
      logic [7:0] op;
      sel  = $urandom_range(0, 5);
      kind = $urandom_range(0, 3);
      op   = (sel < 3) ? 8'h02 : (sel < 5) ? 8'h01 : 8'($urandom_range(3, 255));
      need = (op == 8'h01) ? NP : (op == 8'h02) ? DIMS : 6;
      if (kind < 2)       len = need;
      else if (kind == 2) len = $urandom_range(0, need - 1);
      else                len = need + $urandom_range(1, 3);
      build_pkt({op, 8'($urandom)}, len);
      send_pkt();
      model_pkt();
      repeat (4) @(negedge clk_i);
      check_all($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
